// File: rtl/perf_counter_bank_if.sv
// Control and result bundle for perf_counter_bank.
// The master drives measurement requests and event strobes; the slave returns latched results.
interface perf_counter_bank_if #(
  parameter int COUNTER_WIDTH = 32,
  parameter int NUM_EVENTS    = 8
);
  logic                                start_pulse;
  logic                                done_pulse;
  logic                                pause;
  logic                                accumulate_en;
  logic                                clear_pulse;
  logic                                busy_signal;
  logic [NUM_EVENTS-1:0]               event_valid;
  logic [COUNTER_WIDTH-1:0]            total_cycles_count;
  logic [COUNTER_WIDTH-1:0]            active_cycles_count;
  logic [COUNTER_WIDTH-1:0]            idle_cycles_count;
  logic [NUM_EVENTS*COUNTER_WIDTH-1:0] event_counts;
  logic [NUM_EVENTS+2:0]               overflow_flags;
  logic                                measuring;
  logic                                measurement_done;

  modport master (
    output start_pulse, done_pulse, pause, accumulate_en, clear_pulse,
           busy_signal, event_valid,
    input  total_cycles_count, active_cycles_count, idle_cycles_count,
           event_counts, overflow_flags, measuring, measurement_done
  );

  modport slave (
    input  start_pulse, done_pulse, pause, accumulate_en, clear_pulse,
           busy_signal, event_valid,
    output total_cycles_count, active_cycles_count, idle_cycles_count,
           event_counts, overflow_flags, measuring, measurement_done
  );
endinterface

// File: rtl/perf_counter_bank.sv
// Cycle/event performance counter bank with start/pause/done measurement control.
// Internal counters run while measuring; results are copied to latched outputs
// one cycle after the measurement ends, accompanied by a one-cycle done pulse.
//
// state       | meaning
// S_IDLE      | no measurement; counters frozen, clear_pulse honoured
// S_MEASURING | counting every cycle
// S_PAUSED    | measurement open but counting suspended
module perf_counter_bank #(
  parameter int COUNTER_WIDTH = 32,
  parameter int NUM_EVENTS    = 8,
  parameter int SATURATE      = 1
) (
  input logic          clk,
  input logic          rst,
  perf_counter_bank_if.slave bus
);
  localparam int CW = COUNTER_WIDTH;
  localparam int NF = NUM_EVENTS + 3;

  typedef enum logic [1:0] {S_IDLE, S_MEASURING, S_PAUSED} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CW-1:0]        r_total, r_active, r_idle;
  logic [CW-1:0]        r_evt [NUM_EVENTS];
  logic [NF-1:0]        r_ovf;
  logic [CW-1:0]        r_total_lat, r_active_lat, r_idle_lat;
  logic [NUM_EVENTS*CW-1:0] r_evt_lat;
  logic [NF-1:0]        r_ovf_lat;
  logic                 r_end_d;
  logic                 r_done;
  logic                 w_start_edge;
  logic                 w_end;
  logic [CW:0]          w_total_bump, w_active_bump, w_idle_bump;
  logic [CW:0]          w_evt_bump [NUM_EVENTS];

  // Top bit of the result flags a wrap-around attempt; low bits are the new value.
  function automatic logic [CW:0] f_bump(input logic [CW-1:0] v);
    if (&v) f_bump = {1'b1, (SATURATE != 0) ? v : {CW{1'b0}}};
    else    f_bump = {1'b0, v + 1'b1};
  endfunction

  assign w_total_bump  = f_bump(r_total);
  assign w_active_bump = f_bump(r_active);
  assign w_idle_bump   = f_bump(r_idle);

  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_evt_bump
    assign w_evt_bump[g] = f_bump(r_evt[g]);
  end

  assign w_start_edge = (r_state == S_IDLE) && bus.start_pulse;
  assign w_end        = (r_state != S_IDLE) && bus.done_pulse;

  // Next-state decode; done has priority over pause, start ignored once open.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (bus.start_pulse) w_state_next = S_MEASURING;
      S_MEASURING: if (bus.done_pulse) w_state_next = S_IDLE;
                   else if (bus.pause) w_state_next = S_PAUSED;
      S_PAUSED:    if (bus.done_pulse) w_state_next = S_IDLE;
                   else if (!bus.pause) w_state_next = S_MEASURING;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // State register, internal counters, and latched result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_end_d      <= 1'b0;
      r_done       <= 1'b0;
      r_total      <= '0;
      r_active     <= '0;
      r_idle       <= '0;
      r_ovf        <= '0;
      for (int i = 0; i < NUM_EVENTS; i++) r_evt[i] <= '0;
      r_total_lat  <= '0;
      r_active_lat <= '0;
      r_idle_lat   <= '0;
      r_evt_lat    <= '0;
      r_ovf_lat    <= '0;
    end else begin
      r_state <= w_state_next;
      r_end_d <= w_end;
      r_done  <= r_end_d;

      if ((w_start_edge && !bus.accumulate_en) ||
          (!w_start_edge && (r_state == S_IDLE) && bus.clear_pulse)) begin
        r_total  <= '0;
        r_active <= '0;
        r_idle   <= '0;
        r_ovf    <= '0;
        for (int i = 0; i < NUM_EVENTS; i++) r_evt[i] <= '0;
      end else if (r_state == S_MEASURING) begin
        r_total <= w_total_bump[CW-1:0];
        if (w_total_bump[CW]) r_ovf[0] <= 1'b1;
        if (bus.busy_signal) begin
          r_active <= w_active_bump[CW-1:0];
          if (w_active_bump[CW]) r_ovf[1] <= 1'b1;
        end else begin
          r_idle <= w_idle_bump[CW-1:0];
          if (w_idle_bump[CW]) r_ovf[2] <= 1'b1;
        end
        for (int i = 0; i < NUM_EVENTS; i++) begin
          if (bus.event_valid[i]) begin
            r_evt[i] <= w_evt_bump[i][CW-1:0];
            if (w_evt_bump[i][CW]) r_ovf[3+i] <= 1'b1;
          end
        end
      end

      if (r_end_d) begin
        r_total_lat  <= r_total;
        r_active_lat <= r_active;
        r_idle_lat   <= r_idle;
        r_ovf_lat    <= r_ovf;
        for (int i = 0; i < NUM_EVENTS; i++) r_evt_lat[i*CW +: CW] <= r_evt[i];
      end else if ((r_state == S_IDLE) && bus.clear_pulse) begin
        r_total_lat  <= '0;
        r_active_lat <= '0;
        r_idle_lat   <= '0;
        r_evt_lat    <= '0;
        r_ovf_lat    <= '0;
      end
    end
  end

  assign bus.total_cycles_count  = r_total_lat;
  assign bus.active_cycles_count = r_active_lat;
  assign bus.idle_cycles_count   = r_idle_lat;
  assign bus.event_counts        = r_evt_lat;
  assign bus.overflow_flags      = r_ovf_lat;
  assign bus.measuring           = (r_state != S_IDLE);
  assign bus.measurement_done    = r_done;
endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 32, width of every counter.
REQ-002 SHALL have parameter NUM_EVENTS, default 8, number of generic event counters (1..32).
REQ-003 SHALL have parameter SATURATE, default 1; 1 = counters stick at all-ones, 0 = counters wrap to zero.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port start_pulse, input, 1, single-cycle request to begin a measurement.
REQ-007 SHALL have port done_pulse, input, 1, single-cycle request to end a measurement.
REQ-008 SHALL have port pause, input, 1, level; while high, counting is suspended.
REQ-009 SHALL have port accumulate_en, input, 1, sampled with start_pulse; 1 = keep prior counts.
REQ-010 SHALL have port clear_pulse, input, 1, clears internal counters, flags and outputs when idle.
REQ-011 SHALL have port busy_signal, input, 1, core doing useful work.
REQ-012 SHALL have port event_valid, input, NUM_EVENTS, per-channel event strobe, one count per high cycle.
REQ-013 SHALL have port total_cycles_count, output, COUNTER_WIDTH, latched total measuring cycles.
REQ-014 SHALL have port active_cycles_count, output, COUNTER_WIDTH, latched cycles with busy_signal high.
REQ-015 SHALL have port idle_cycles_count, output, COUNTER_WIDTH, latched cycles with busy_signal low.
REQ-016 SHALL have port event_counts, output, NUM_EVENTS*COUNTER_WIDTH, latched event counts, channel i at bits [i*COUNTER_WIDTH +: COUNTER_WIDTH].
REQ-017 SHALL have port overflow_flags, output, NUM_EVENTS+3, latched sticky overflow; bit0 total, bit1 active, bit2 idle, bit 3+i event i.
REQ-018 SHALL have port measuring, output, 1, high when state is not S_IDLE.
REQ-019 SHALL have port measurement_done, output, 1, single-cycle pulse when latched outputs update.

Function
REQ-020 SHALL implement FSM states S_IDLE, S_MEASURING, S_PAUSED.
REQ-021 S_IDLE -> S_MEASURING on start_pulse; done_pulse in S_IDLE ignored, so start+done together in S_IDLE starts.
REQ-022 S_MEASURING -> S_IDLE on done_pulse; else -> S_PAUSED if pause high; done_pulse has priority over pause.
REQ-023 S_PAUSED -> S_IDLE on done_pulse; else -> S_MEASURING when pause low.
REQ-024 start_pulse in S_MEASURING or S_PAUSED SHALL be ignored.
REQ-025 On the S_IDLE -> S_MEASURING edge, internal counters and sticky flags SHALL clear to zero unless accumulate_en is high, in which case they hold.
REQ-026 In every cycle with state S_MEASURING (including the cycle done_pulse is sampled), total SHALL increment, active if busy_signal else idle, and event i if event_valid[i].
REQ-027 In S_PAUSED and S_IDLE, no counter SHALL change except by REQ-025/REQ-030.
REQ-028 A counter at all-ones that would increment SHALL set its sticky flag and either hold (SATURATE=1) or become zero (SATURATE=0).
REQ-029 One cycle after the state enters S_IDLE from S_MEASURING or S_PAUSED, all latched outputs SHALL load the internal values and measurement_done SHALL be high for exactly that cycle.
REQ-030 clear_pulse in S_IDLE SHALL zero internal counters, flags and latched outputs next cycle without pulsing measurement_done; ignored otherwise.
REQ-031 Latched outputs SHALL hold between measurements; measuring SHALL reflect the registered state.

Reset
REQ-032 rst high at a clock edge SHALL force S_IDLE and zero all counters, flags, latched outputs, measuring and measurement_done, including mid-measurement, with no measurement_done pulse.

Verification
REQ-033 NUM_EVENTS=4; start, 10 S_MEASURING cycles, busy high 6 and low 4, event_valid[0] high 3 cycles, done -> total 10, active 6, idle 4, event0 3, others 0, one measurement_done pulse.
REQ-034 7 S_MEASURING cycles with 3 S_PAUSED cycles interleaved -> total 7; done during pause -> S_IDLE, outputs latch.
REQ-035 COUNTER_WIDTH=4, 20 measuring cycles: SATURATE=1 -> total 15, overflow_flags[0]=1; SATURATE=0 -> total 4, overflow_flags[0]=1.
REQ-036 Run of 10 cycles, then start with accumulate_en=1 and 5 cycles -> total 15; start with accumulate_en=0 and 5 cycles -> total 5.
REQ-037 rst for one cycle mid-measurement -> all outputs 0, measuring 0; a later done_pulse produces no measurement_done.
REQ-038 start_pulse and done_pulse together in S_IDLE -> measuring high next cycle; clear_pulse while measuring has no effect.
